// File: rtl/mem_port_arbiter.sv
// Arbitrates a read-only fetch port and a read/write data port onto the single-port Memory bus.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ack,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, DONE} state_t;

    state_t               state_q, state_d;
    logic                 sel_d_q, sel_d_d;   // 1 = data port owns the transaction
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 read_m_q, read_m_d;
    logic                 write_m_q, write_m_d;
    logic                 i_ack_q, i_ack_d;
    logic                 d_ack_q, d_ack_d;
    logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic                 favour_d_port;
    logic                 d_wins;

`ifdef MEM_ARB_RR_EN
    logic ptr_q, ptr_d;
    assign favour_d_port = ptr_q;
`else
    assign favour_d_port = 1'b1;
`endif

    assign d_wins = d_req && (!i_req || favour_d_port);

    always_comb begin
        // NOTE: every _d gets its hold/idle value first so no path can infer a latch.
        state_d   = state_q;
        sel_d_d   = sel_d_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        read_m_d  = 1'b0;
        write_m_d = 1'b0;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        ptr_d     = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    sel_d_d = d_wins;
                    addr_d  = d_wins ? d_addr : i_addr;
                    if (d_wins && d_we) begin
                        wdata_d   = d_wdata;
                        write_m_d = 1'b1;
                        state_d   = WR;
                    end else begin
                        read_m_d = 1'b1;
                        state_d  = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                read_m_d = 1'b1;
                state_d  = RD_DATA;
            end
            RD_DATA: begin
                // Memory's registered output is on the bus during this cycle.
                state_d = DONE;
                if (sel_d_q) begin
                    d_rdata_d = data;
                    d_ack_d   = 1'b1;
                end else begin
                    i_rdata_d = data;
                    i_ack_d   = 1'b1;
                end
            end
            WR: begin
                state_d = DONE;
                d_ack_d = sel_d_q;
                i_ack_d = !sel_d_q;
            end
            DONE: begin
                state_d = IDLE;
`ifdef MEM_ARB_RR_EN
                ptr_d   = !sel_d_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sel_d_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            read_m_q  <= 1'b0;
            write_m_q <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            ptr_q     <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            sel_d_q   <= sel_d_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            read_m_q  <= read_m_d;
            write_m_q <= write_m_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign readM   = read_m_q;
    assign writeM  = write_m_q;
    assign address = addr_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign data    = write_m_q ? wdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expectations, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int W       = 16;
    localparam int TIMEOUT = 200;

    typedef struct packed { logic we; logic [W-1:0] rdata; } d_exp_t;
    typedef struct packed { logic [W-1:0] addr; logic [W-1:0] wdata; } w_exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [W-1:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic         i_ack, d_ack, readM, writeM;
    logic [W-1:0] i_rdata, d_rdata, address;
    wire  [W-1:0] data;

    logic [W-1:0] mem [256];
    logic [W-1:0] mem_out;
    logic [W-1:0] ref_mem [256];

    logic [W-1:0] i_exp_q [$];
    d_exp_t       d_exp_q [$];
    w_exp_t       w_exp_q [$];
    byte          grant_log [$];

    int           total = 0, bad = 0, ack_count = 0;
    logic [W-1:0] i_hold = '0, d_hold = '0;
    logic [W-1:0] zz = 'z;
    logic [W-1:0] i_e;
    d_exp_t       d_e;
    w_exp_t       w_e;
    bit           d_done;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WORD_SIZE(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .readM(readM), .writeM(writeM), .address(address), .data(data)
    );

    // Single-port memory with registered read output, decoding the low 8 address bits.
    always @(posedge clk) begin
        if (writeM) mem[address[7:0]] <= data;
        if (readM)  mem_out <= mem[address[7:0]];
    end
    assign data = readM ? mem_out : 'z;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            i_hold = '0;
            d_hold = '0;
        end else begin
            check("rw_exclusive", {31'd0, readM && writeM}, 32'd0);
            check("ack_exclusive", {31'd0, i_ack && d_ack}, 32'd0);
            if (!readM && !writeM) check("bus_z", data, zz);
            if (writeM) begin
                if (w_exp_q.size() == 0) fail_event("unexpected_write");
                else begin
                    w_e = w_exp_q.pop_front();
                    check("wr_address", address, w_e.addr);
                    check("wr_data", data, w_e.wdata);
                end
            end
            if (i_ack) begin
                ack_count++;
                grant_log.push_back("I");
                if (i_exp_q.size() == 0) fail_event("unexpected_i_ack");
                else begin
                    i_e = i_exp_q.pop_front();
                    check("i_rdata", i_rdata, i_e);
                    i_hold = i_e;
                end
                check("d_rdata_held", d_rdata, d_hold);
            end
            if (d_ack) begin
                ack_count++;
                grant_log.push_back("D");
                if (d_exp_q.size() == 0) fail_event("unexpected_d_ack");
                else begin
                    d_e = d_exp_q.pop_front();
                    if (!d_e.we) begin
                        check("d_rdata", d_rdata, d_e.rdata);
                        d_hold = d_e.rdata;
                    end else begin
                        check("d_rdata_after_write", d_rdata, d_hold);
                    end
                end
                check("i_rdata_held", i_rdata, i_hold);
            end
        end
    end

    // Callers enter just after a rising edge; req is dropped at the edge ending the ack cycle.
    task automatic do_fetch(input logic [W-1:0] addr, input int exp_lat);
        int n, rd;
        bit got;
        i_exp_q.push_back(ref_mem[addr[7:0]]);
        i_req = 1'b1;
        i_addr = addr;
        n = 0; rd = 0; got = 0;
        while (!got && n < TIMEOUT) begin
            @(negedge clk);
            n++;
            if (readM) rd++;
            if (i_ack) got = 1;
        end
        if (!got) fail_event("fetch_timeout");
        else if (exp_lat >= 0) begin
            check("fetch_latency", n - 1, exp_lat);
            if (exp_lat == 3) check("fetch_readM_cycles", rd, 2);
        end
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                           input int exp_lat);
        int n, rd, wr;
        bit got;
        if (we) begin
            ref_mem[addr[7:0]] = wdata;
            d_exp_q.push_back('{we: 1'b1, rdata: '0});
            w_exp_q.push_back('{addr: addr, wdata: wdata});
        end else begin
            d_exp_q.push_back('{we: 1'b0, rdata: ref_mem[addr[7:0]]});
        end
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        n = 0; rd = 0; wr = 0; got = 0;
        while (!got && n < TIMEOUT) begin
            @(negedge clk);
            n++;
            if (readM) rd++;
            if (writeM) wr++;
            if (d_ack) got = 1;
        end
        if (!got) fail_event("data_timeout");
        else if (exp_lat >= 0) begin
            check("data_latency", n - 1, exp_lat);
            if (we) check("writeM_cycles", wr, 1);
            else if (exp_lat == 3) check("data_readM_cycles", rd, 2);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string exp_order;
        int    ack_snap;
        for (int i = 0; i < 256; i++) begin
            mem[i] = W'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[8'h00] = 16'h9023; mem[8'h23] = 16'h6000; mem[8'h01] = 16'h0001;
        mem[8'h02] = 16'hFFFF; mem[8'h24] = 16'hF01C;
        ref_mem[8'h00] = 16'h9023; ref_mem[8'h23] = 16'h6000; ref_mem[8'h01] = 16'h0001;
        ref_mem[8'h02] = 16'hFFFF; ref_mem[8'h24] = 16'hF01C;

        // Reset values
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_readM", readM, 0);
        check("rst_writeM", writeM, 0);
        check("rst_i_ack", i_ack, 0);
        check("rst_d_ack", d_ack, 0);
        check("rst_address", address, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_data_z", data, zz);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Fetch reads with nominal latency
        do_fetch(16'h0000, 3);
        do_fetch(16'h0023, 3);

        // Data write then read back
        do_data(1'b1, 16'h00F0, 16'hBEEF, 2);
        do_data(1'b0, 16'h00F0, 16'h0000, 3);

        // Simultaneous requests from a fresh reset: data first, fetch waits one full read
        pulse_reset();
        fork
            do_data(1'b0, 16'h0001, 16'h0000, 3);
            do_fetch(16'h0002, 7);
        join

        // Both ports requesting continuously
        pulse_reset();
        grant_log.delete();
        d_done = 0;
        fork
            begin
                repeat (4) do_data(1'b0, W'($urandom), 16'h0000, -1);
                d_done = 1;
            end
            begin
                while (!d_done) do_fetch({8'($urandom), 1'b0, 7'($urandom)}, -1);
            end
        join
`ifdef MEM_ARB_RR_EN
        exp_order = "DIDI";
`else
        exp_order = "DDDD";
`endif
        if (grant_log.size() < 4) fail_event("grant_log_short");
        else for (int i = 0; i < 4; i++) check($sformatf("grant_order_%0d", i), grant_log[i], exp_order[i]);

        // Reset during RD_DATA abandons the read
        ack_snap = ack_count;
        i_req = 1'b1;
        i_addr = 16'h0024;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_abort_readM", readM, 1);
        reset_n = 1'b0;
        #1;
        check("abort_readM", readM, 0);
        check("abort_i_ack", i_ack, 0);
        check("abort_address", address, 0);
        check("abort_data_z", data, zz);
        i_req = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("no_ack_after_abort", ack_count, ack_snap);
        @(posedge clk); #1;
        do_fetch(16'h0024, 3);

        // Random traffic: fetch reads the low half, data writes the high half, reads anywhere
        fork
            begin
                for (int k = 0; k < 25; k++) begin
                    do_fetch({8'($urandom), 1'b0, 7'($urandom)}, -1);
                    repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int k = 0; k < 25; k++) begin
                    if ($urandom_range(1, 0) == 1)
                        do_data(1'b1, {8'($urandom), 1'b1, 7'($urandom)}, W'($urandom), -1);
                    else
                        do_data(1'b0, W'($urandom), 16'h0000, -1);
                    repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
                end
            end
        join
        repeat (5) @(negedge clk);
        check("i_queue_drained", i_exp_q.size(), 0);
        check("d_queue_drained", d_exp_q.size(), 0);
        check("w_queue_drained", w_exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
